// File: rtl/led_pwm_pkg.sv
// ---------------------------------------------------------------------------
// led_pwm_pkg
// Shared types and elaboration-time helpers for the multi-channel LED PWM
// controller.
//   led_mode_t      per-channel operating mode (OFF, ON, BREATH, BLINK)
//   calc_pre        clk cycles per PWM tick
//   calc_step_div   PWM periods per breath phase step
//   calc_blink_div  PWM periods per blink half-cycle
//   tri_fold        folds a DUTY_W+1 bit phase into a DUTY_W bit triangle
// Optional feature macro used by the channel module: LED_PWM_GAMMA_EN
// ---------------------------------------------------------------------------
package led_pwm_pkg;

    typedef enum logic [1:0] {
        OFF    = 2'd0,
        ON     = 2'd1,
        BREATH = 2'd2,
        BLINK  = 2'd3
    } led_mode_t;

    // Integer floor division clamped to a minimum of 1, done in 64 bits so
    // that MHz * 1e6 products cannot overflow.
    function automatic int clamp_div(input longint num, input longint den);
        longint q;
        q = num / den;
        return (q < 64'sd1) ? 1 : int'(q);
    endfunction

    function automatic int calc_pre(input int clk_fre, input int pwm_rate,
                                    input int duty_w);
        return clamp_div(longint'(clk_fre) * 64'sd1000000,
                         longint'(pwm_rate) * (64'sd1 << duty_w));
    endfunction

    function automatic int calc_step_div(input int breath_ms, input int pwm_rate,
                                         input int duty_w);
        return clamp_div(longint'(breath_ms) * longint'(pwm_rate),
                         64'sd2000 * (64'sd1 << duty_w));
    endfunction

    function automatic int calc_blink_div(input int blink_ms, input int pwm_rate);
        return clamp_div(longint'(blink_ms) * longint'(pwm_rate), 64'sd1000);
    endfunction

    // Upper half of the phase range counts the low bits back down, giving a
    // symmetric ramp up then ramp down over one full phase revolution.
    function automatic int unsigned tri_fold(input int unsigned phase,
                                             input int unsigned duty_w);
        int unsigned mask;
        int unsigned low;
        mask = (32'd1 << duty_w) - 32'd1;
        low  = phase & mask;
        return (((phase >> duty_w) & 32'd1) != 32'd0) ? (mask ^ low) : low;
    endfunction

endpackage

// File: rtl/led_breath_ch.sv
// ---------------------------------------------------------------------------
// led_breath_ch
// One LED channel: breath phase counter, mode register, per-period duty latch
// and the PWM compare that drives the output pin.
// Ports:
//   clk, rst     system clock, synchronous active-high reset
//   pcnt         shared PWM period counter
//   wrap         high on the clk edge where pcnt wraps to 0 (period start)
//   step_stb     breath phase advance strobe (coincides with a wrap)
//   blink_on     shared blink toggle
//   cfg_we       commit a new mode on this wrap
//   cfg_mode     mode to commit
//   led          registered PWM output, active-high
// Macro LED_PWM_GAMMA_EN: breath duty passes through a square law through one
// extra register before being latched.
// ---------------------------------------------------------------------------
module led_breath_ch
    import led_pwm_pkg::*;
#(
    parameter int DUTY_W     = 10,
    parameter int PHASE_INIT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DUTY_W-1:0] pcnt,
    input  logic              wrap,
    input  logic              step_stb,
    input  logic              blink_on,
    input  logic              cfg_we,
    input  led_mode_t         cfg_mode,
    output logic              led
);

    localparam logic [DUTY_W:0] PH0 = PHASE_INIT[DUTY_W:0];

    logic [DUTY_W:0]   phase;
    led_mode_t         mode;
    led_mode_t         mode_nxt;
    logic [DUTY_W-1:0] duty_l;
    logic [DUTY_W-1:0] duty_tri;
    logic [DUTY_W-1:0] duty_br;
    logic [DUTY_W-1:0] duty_nxt;

    // The duty latched at a period start must already follow the mode that
    // becomes active at that same edge, so the new mode starts on a clean
    // period boundary.
    assign mode_nxt = cfg_we ? cfg_mode : mode;
    assign duty_tri = DUTY_W'(tri_fold(32'(phase), DUTY_W));

`ifdef LED_PWM_GAMMA_EN
    logic [DUTY_W-1:0] duty_g_p1;

    function automatic logic [DUTY_W-1:0] gamma_sq(input logic [DUTY_W-1:0] d);
        logic [2*DUTY_W-1:0] sq;
        sq = d * d;
        return sq[2*DUTY_W-1:DUTY_W];
    endfunction

    // Gamma stage: phase only moves at period start, so this register has
    // settled long before the next latch point.
    always_ff @(posedge clk) begin
        if (rst) begin
            duty_g_p1 <= '0;
        end else begin
            duty_g_p1 <= gamma_sq(duty_tri);
        end
    end

    assign duty_br = duty_g_p1;
`else
    assign duty_br = duty_tri;
`endif

    always_comb begin
        duty_nxt = '0;
        case (mode_nxt)
            BREATH:  duty_nxt = duty_br;
            BLINK:   duty_nxt = {DUTY_W{blink_on}};
            default: duty_nxt = '0;
        endcase
    end

    // Phase keeps running in every mode so channels stay in their fixed
    // relative offsets whenever they re-enter BREATH.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase  <= PH0;
            mode   <= BREATH;
            duty_l <= '0;
            led    <= 1'b0;
        end else begin
            if (step_stb) begin
                phase <= phase + 1'b1;
            end
            if (wrap) begin
                mode   <= mode_nxt;
                duty_l <= duty_nxt;
            end
            led <= (mode == ON) || (pcnt < duty_l);
        end
    end

endmodule

// File: rtl/led_pwm_multi.sv
// ---------------------------------------------------------------------------
// led_pwm_multi
// Multi-channel LED PWM controller. One shared prescaler and period counter
// feed CH_NUM channels, each in OFF / ON / BREATH / BLINK mode. Mode changes
// come in over a valid/ready port and take effect at the next period start.
// Ports:
//   clk         system clock
//   rst         synchronous reset, active-high
//   cfg_valid   config request
//   cfg_ready   request accepted on cfg_valid && cfg_ready
//   cfg_ch      target channel (values >= CH_NUM are accepted and dropped)
//   cfg_mode    led_mode_t encoding
//   period_stb  one-clk pulse at each PWM period start
//   led         PWM outputs, active-high
// Macro LED_PWM_GAMMA_EN (in led_breath_ch): square-law breath duty.
// ---------------------------------------------------------------------------
module led_pwm_multi
    import led_pwm_pkg::*;
#(
    parameter  int CLK_FRE   = 50,
    parameter  int CH_NUM    = 4,
    parameter  int DUTY_W    = 10,
    parameter  int PWM_RATE  = 10_000,
    parameter  int BREATH_MS = 2000,
    parameter  int BLINK_MS  = 500,
    localparam int CH_W      = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [1:0]        cfg_mode,
    output logic              period_stb,
    output logic [CH_NUM-1:0] led
);

    localparam int PRE       = calc_pre(CLK_FRE, PWM_RATE, DUTY_W);
    localparam int STEP_DIV  = calc_step_div(BREATH_MS, PWM_RATE, DUTY_W);
    localparam int BLINK_DIV = calc_blink_div(BLINK_MS, PWM_RATE);
    localparam int PRE_W     = $clog2(PRE + 1);
    localparam int STEP_W    = $clog2(STEP_DIV + 1);
    localparam int BLINK_W   = $clog2(BLINK_DIV + 1);
    localparam int PH_SPAN   = (2 ** (DUTY_W + 1)) / CH_NUM;

    logic [PRE_W-1:0]   pre_cnt;
    logic [DUTY_W-1:0]  pcnt;
    logic [STEP_W-1:0]  step_cnt;
    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_on;
    logic               tick;
    logic               wrap;
    logic               step_stb;

    logic               pend_vld;
    logic [CH_W-1:0]    pend_ch;
    led_mode_t          pend_mode;
    logic               accept;
    logic               commit;

    assign tick     = (pre_cnt == PRE_W'(PRE - 1));
    assign wrap     = tick && (pcnt == {DUTY_W{1'b1}});
    assign step_stb = wrap && (step_cnt == STEP_W'(STEP_DIV - 1));

    // Shared timebase: prescaler, period counter, breath and blink dividers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt    <= '0;
            pcnt       <= '0;
            period_stb <= 1'b0;
            step_cnt   <= '0;
            blink_cnt  <= '0;
            blink_on   <= 1'b0;
        end else begin
            pre_cnt    <= tick ? '0 : pre_cnt + 1'b1;
            period_stb <= wrap;
            if (tick) begin
                pcnt <= pcnt + 1'b1;
            end
            if (wrap) begin
                step_cnt <= (step_cnt == STEP_W'(STEP_DIV - 1)) ? '0 : step_cnt + 1'b1;
                if (blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
                    blink_cnt <= '0;
                    blink_on  <= ~blink_on;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end
        end
    end

    // Single-entry config buffer. Ready is simply "nothing pending", so a new
    // request cannot land on the same edge as a commit. A request accepted on
    // the wrap edge itself is not yet pending there and so waits a full
    // period for the following wrap.
    assign cfg_ready = ~pend_vld;
    assign accept    = cfg_valid && cfg_ready;
    assign commit    = wrap && pend_vld;

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_vld  <= 1'b0;
            pend_ch   <= '0;
            pend_mode <= BREATH;
        end else if (accept) begin
            pend_vld  <= 1'b1;
            pend_ch   <= cfg_ch;
            pend_mode <= led_mode_t'(cfg_mode);
        end else if (commit) begin
            pend_vld  <= 1'b0;
        end
    end

    // Out-of-range channel numbers match no instance and are dropped here.
    for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
        led_breath_ch #(
            .DUTY_W     (DUTY_W),
            .PHASE_INIT (i * PH_SPAN)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .pcnt     (pcnt),
            .wrap     (wrap),
            .step_stb (step_stb),
            .blink_on (blink_on),
            .cfg_we   (commit && (pend_ch == CH_W'(i))),
            .cfg_mode (pend_mode),
            .led      (led[i])
        );
    end

endmodule

// File: tb/tb_led_pwm_multi.sv
// ---------------------------------------------------------------------------
// tb_led_pwm_multi
// Bench for led_pwm_multi with CLK_FRE=1, DUTY_W=4, PWM_RATE=31250,
// BREATH_MS=2, BLINK_MS=1 (PRE=2, period 32 clk, STEP_DIV=1, BLINK_DIV=31).
// Two instances share all inputs: a 4-channel one and a 3-channel one, the
// latter so a 2-bit cfg_ch value (3) can be out of range.
// The reference model computes every output from the clock count since
// reset and the list of accepted requests. LED_PWM_GAMMA_EN selects the
// square-law breath model.
// ---------------------------------------------------------------------------
module tb_led_pwm_multi;

    localparam int PRE       = 2;
    localparam int PER       = 32;
    localparam int STEP_DIV  = 1;
    localparam int BLINK_DIV = 31;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cfg_valid = 1'b0;
    logic [1:0] cfg_ch = 2'd0;
    logic [1:0] cfg_mode = 2'd0;
    logic       cfg_ready4, stb4, cfg_ready3, stb3;
    logic [3:0] led4;
    logic [2:0] led3;
    logic [10:0] obs;

    always #5 clk = ~clk;

    led_pwm_multi #(.CLK_FRE(1), .CH_NUM(4), .DUTY_W(4), .PWM_RATE(31250),
                    .BREATH_MS(2), .BLINK_MS(1)) dut4 (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready4),
        .cfg_ch(cfg_ch), .cfg_mode(cfg_mode), .period_stb(stb4), .led(led4));

    led_pwm_multi #(.CLK_FRE(1), .CH_NUM(3), .DUTY_W(4), .PWM_RATE(31250),
                    .BREATH_MS(2), .BLINK_MS(1)) dut3 (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready3),
        .cfg_ch(cfg_ch), .cfg_mode(cfg_mode), .period_stb(stb3), .led(led3));

    assign obs = {cfg_ready3, stb3, led3, cfg_ready4, stb4, led4};

    int checks   = 0;
    int failures = 0;
    int n        = 0;   // clk edges since the last reset edge

    typedef struct { int ch; int mode; int a; int c; } ev_t;
    ev_t evq[$];        // accepted requests: accept edge a, commit period c

    // ---------------- reference model ----------------
    function automatic int mode_at(input int ch, input int p);
        int m;
        m = 2;
        foreach (evq[k]) if (evq[k].ch == ch && evq[k].c <= p) m = evq[k].mode;
        return m;
    endfunction

    function automatic logic exp_led(input int ch, input int nch, input int nn);
        int q, p, m, d, ph, t;
        if (nn == 0) return 1'b0;
        q = nn - 1;
        p = q / PER;
        m = mode_at(ch, p);
        if (m == 1) return 1'b1;
        d = 0;
        if (p > 0) begin
            if (m == 2) begin
                ph = (ch * (32 / nch) + (p - 1) / STEP_DIV) % 32;
                t  = (ph < 16) ? ph : 31 - ph;
`ifdef LED_PWM_GAMMA_EN
                t = (t * t) / 16;
`endif
                d = t;
            end else if (m == 3) begin
                d = ((((p - 1) / BLINK_DIV) % 2) == 1) ? 15 : 0;
            end
        end
        return (((q % PER) / PRE) < d) ? 1'b1 : 1'b0;
    endfunction

    function automatic logic exp_ready(input int nn);
        foreach (evq[k]) if (nn >= evq[k].a && nn < evq[k].c * PER) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [10:0] exp_all(input int nn);
        logic [3:0] v4;
        logic [2:0] v3;
        logic r, s;
        for (int c = 0; c < 4; c++) v4[c] = exp_led(c, 4, nn);
        for (int c = 0; c < 3; c++) v3[c] = exp_led(c, 3, nn);
        r = exp_ready(nn);
        s = (nn > 0) && ((nn % PER) == 0);
        return {r, s, v3, r, s, v4};
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
        if (rst) begin
            n = 0;
            evq.delete();
        end else begin
            n++;
        end
    endtask

    task automatic advance_to(input int ph);
        for (int w = 0; w < PER && (n % PER) != ph; w++) step();
    endtask

    task automatic send(input int ch, input int mode);
        ev_t e;
        for (int w = 0; w < 4 * PER && !cfg_ready4; w++) step();
        if (!cfg_ready4) begin
            checks++;
            failures++;
            $display("FAIL send_timeout ch=%0d cfg_ready=%b required 1", ch, cfg_ready4);
            return;
        end
        cfg_valid = 1'b1;
        cfg_ch    = 2'(ch);
        cfg_mode  = 2'(mode);
        e.ch = ch; e.mode = mode; e.a = n + 1; e.c = (n + 1) / PER + 1;
        evq.push_back(e);
        step();
        cfg_valid = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [10:0] e;
        rst = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            checks++;
            if (led4 !== 4'b0 || led3 !== 3'b0 || stb4 !== 1'b0 || cfg_ready4 !== 1'b1
                || cfg_ready3 !== 1'b1) begin
                failures++;
                $display("FAIL reset_state led4=%b led3=%b stb=%b rdy=%b required 0 0 0 1",
                         led4, led3, stb4, cfg_ready4);
            end
        end
        rst = 1'b0;
        for (int k = 0; k < PER + 8; k++) begin
            step();
            e = exp_all(n);
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL reset_release n=%0d got=%b required=%b", n, obs, e);
            end
        end
    endtask

    task automatic test_breath();
        logic [10:0] e;
        for (int k = 0; k < 34 * PER; k++) begin
            step();
            e = exp_all(n);
            checks++;
            if (obs !== e) begin
                failures++;
                if (failures < 40) $display("FAIL breath n=%0d got=%b required=%b", n, obs, e);
            end
        end
    endtask

    task automatic test_cfg_on();
        logic [10:0] e;
        advance_to(int'($urandom_range(5, 25)));
        send(1, 1);
        checks++;
        if (cfg_ready4 !== 1'b0) begin
            failures++;
            $display("FAIL cfg_on_ready_drop cfg_ready=%b required 0", cfg_ready4);
        end
        for (int k = 0; k < 3 * PER; k++) begin
            step();
            e = exp_all(n);
            checks++;
            if (obs !== e) begin
                failures++;
                if (failures < 40) $display("FAIL cfg_on n=%0d got=%b required=%b", n, obs, e);
            end
        end
    endtask

    task automatic test_blink();
        logic [10:0] e;
        advance_to(int'($urandom_range(3, 28)));
        send(3, 3);
        for (int k = 0; k < 66 * PER; k++) begin
            step();
            e = exp_all(n);
            checks++;
            if (obs !== e) begin
                failures++;
                if (failures < 40) $display("FAIL blink n=%0d got=%b required=%b", n, obs, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [10:0] e;
        advance_to(PER - 1);
        // accepted exactly on the wrap edge: commit is one full period later
        send(0, 0);
        checks++;
        if (stb4 !== 1'b1 || cfg_ready4 !== 1'b0) begin
            failures++;
            $display("FAIL b2b_accept_on_stb stb=%b rdy=%b required 1 0", stb4, cfg_ready4);
        end
        for (int k = 0; k < PER + 2; k++) begin
            step();
            e = exp_all(n);
            checks++;
            if (obs !== e) begin
                failures++;
                if (failures < 40) $display("FAIL b2b_first n=%0d got=%b required=%b", n, obs, e);
            end
        end
        send(2, 1);
        for (int k = 0; k < 3 * PER; k++) begin
            step();
            e = exp_all(n);
            checks++;
            if (obs !== e) begin
                failures++;
                if (failures < 40) $display("FAIL b2b_second n=%0d got=%b required=%b", n, obs, e);
            end
        end
    endtask

    task automatic test_oor_reset();
        logic [10:0] e;
        advance_to(12);
        send(3, 0);   // out of range for the 3-channel instance
        for (int k = 0; k < 3 * PER; k++) begin
            step();
            e = exp_all(n);
            checks++;
            if (obs !== e) begin
                failures++;
                if (failures < 40) $display("FAIL out_of_range n=%0d got=%b required=%b", n, obs, e);
            end
        end
        advance_to(10);
        send(0, 1);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (led4 !== 4'b0 || led3 !== 3'b0 || cfg_ready4 !== 1'b1 || stb4 !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset led4=%b led3=%b rdy=%b stb=%b required 0 0 1 0",
                     led4, led3, cfg_ready4, stb4);
        end
        for (int k = 0; k < 4 * PER; k++) begin
            step();
            e = exp_all(n);
            checks++;
            if (obs !== e) begin
                failures++;
                if (failures < 40) $display("FAIL after_reset n=%0d got=%b required=%b", n, obs, e);
            end
        end
    endtask

    task automatic test_random();
        logic [10:0] e;
        int len;
        for (int it = 0; it < 12; it++) begin
            len = int'($urandom_range(1, 70));
            for (int k = 0; k < len; k++) begin
                step();
                e = exp_all(n);
                checks++;
                if (obs !== e) begin
                    failures++;
                    if (failures < 40) $display("FAIL random n=%0d got=%b required=%b", n, obs, e);
                end
            end
            send(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end
        for (int k = 0; k < 3 * PER; k++) begin
            step();
            e = exp_all(n);
            checks++;
            if (obs !== e) begin
                failures++;
                if (failures < 40) $display("FAIL random_tail n=%0d got=%b required=%b", n, obs, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_breath();
        test_cfg_on();
        test_blink();
        test_back_to_back();
        test_oor_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
